ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares the data RAM (scalar port a, vector port b) between the pipeline memory stage and a DMA loader used for host/image transfers.
- Sits between the ExecuteMemory register outputs, the RAM, and the MemoryWriteback register inputs.
- Grants one requester per cycle and runs DMA bursts.
- Drives a stall to the pipeline whenever the CPU is refused, and bounds DMA starvation with a wait counter.

Parameters:
- ADDR_W, 16, scalar RAM address width (port a).
- VADDR_W, 12, vector RAM address width (port b); equals the low bits of the CPU address.
- DATA_W, 8, scalar data width.
- VEC_W, 128, vector data width.
- MAX_WAIT, 4, consecutive refused DMA cycles before DMA is forced to win arbitration.
- LEN_W, 4, DMA burst-length field width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  memory-stage access request, for a load or a store.
- cpu_we_a  in  1  scalar store enable.
- cpu_we_b  in  1  vector store enable.
- cpu_addr  in  ADDR_W  access address; port b uses [VADDR_W-1:0].
- cpu_wdata  in  DATA_W  scalar store data.
- cpu_vwdata  in  VEC_W  vector store data.
- cpu_stall  out  1  freeze PC/IF/ID/EX/MEM registers this cycle.
- cpu_rdata  out  DATA_W  scalar read data.
- cpu_vrdata  out  VEC_W  vector read data.
- cpu_rvalid  out  1  read data valid.
- dma_req  in  1  DMA burst request.
- dma_we  in  1  burst is a write (1) or a read (0).
- dma_addr  in  ADDR_W  burst start address; sampled at burst start.
- dma_len  in  LEN_W  beats minus 1; sampled at burst start.
- dma_wdata  in  DATA_W  write data for the current beat.
- dma_gnt  out  1  current beat accepted this cycle.
- dma_rdata  out  DATA_W  read data.
- dma_rvalid  out  1  read data valid.
- dma_done  out  1  one-cycle pulse on the last beat.
- ram_address_a  out  ADDR_W  RAM port a address.
- ram_address_b  out  VADDR_W  RAM port b address.
- ram_data_a  out  DATA_W  RAM port a write data.
- ram_data_b  out  VEC_W  RAM port b write data.
- ram_wren_a  out  1  RAM port a write enable.
- ram_wren_b  out  1  RAM port b write enable.
- ram_q_a  in  DATA_W  RAM port a read data; 1-cycle registered latency.
- ram_q_b  in  VEC_W  RAM port b read data; 1-cycle registered latency.

Behaviour:
- States: IDLE, CPU_OWN, DMA_BURST. Registered state, beat counter, address counter, wait counter, read-tag register.
- Reset (reset=0, async): state IDLE, all counters 0. All outputs 0: stall, rvalid, gnt, done, wren, and data/address buses.
- Arbitration (IDLE/CPU_OWN, combinational on the registered state):
  - if wait_cnt==MAX_WAIT and dma_req → DMA wins;
  - else if cpu_req → CPU wins;
  - else if dma_req → DMA wins;
  - else IDLE.
- CPU win:
  - state CPU_OWN; RAM ports driven from the cpu_* inputs in the same cycle; cpu_stall=0.
  - Scalar store on port a, vector store on port b. cpu_we_a and cpu_we_b are both honoured if both are set.
  - wait_cnt increments (saturating at MAX_WAIT) if dma_req is high.
- DMA win:
  - latches dma_addr and dma_len; state DMA_BURST; dma_gnt=1 for beat 0; wait_cnt cleared.
- DMA_BURST:
  - dma_gnt=1 every cycle; port a only; ram_address_a = base + beat; ram_wren_a = dma_we; port b wren=0.
  - cpu_stall = cpu_req.
  - After the beat with beat==len: dma_done=1 that cycle, then return to arbitration next cycle.
  - A pending cpu_req wins the first post-burst cycle unless wait_cnt has already saturated again.
- Stall: cpu_stall = cpu_req & ~cpu_granted. Combinational; no reliance on a registered stall.
- Read return:
  - Any granted read (we=0) sets a tag register for one cycle.
  - In the next cycle the matching *_rvalid=1, with *_rdata taken directly from ram_q_*.
  - cpu_rvalid and dma_rvalid are never high together.
- Address wrap: the DMA address counter wraps modulo 2^ADDR_W; no error is raised.
- dma_req dropped mid-burst: ignored; the burst runs to completion.
- Reset mid-burst: burst aborted; an in-flight rvalid is suppressed; no dma_done.
- Idle cycles: RAM write enables are 0 and addresses hold their last value.

Optional Feature:
- ARB_PERF_COUNTERS_EN defined:
  - adds outputs stall_cycles[31:0] and dma_beats[31:0];
  - counters are saturating, cleared by reset, and increment per cpu_stall cycle and per dma_gnt cycle.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- CPU only: cpu_req=1, we_a=0, addr=0x0010, RAM[0x10]=0x5A → no stall; next cycle cpu_rvalid=1, cpu_rdata=0x5A.
- DMA write burst on an idle bus: dma_req, we=1, addr=0x0100, len=3 → dma_gnt for 4 cycles, writes to 0x100–0x103, dma_done on the 4th beat; a concurrent cpu_req sees cpu_stall=1 for exactly those 4 cycles.
- Starvation:
  - stimulus: cpu_req held high with dma_req=1 from cycle 0;
  - response: CPU wins cycles 0–3 (wait_cnt reaches 4), DMA burst starts in cycle 4, and cpu_stall=1 from cycle 4 through the burst.
- Vector store: cpu_we_b=1, addr=0x0F20, vwdata=0x00..0F → ram_wren_b=1, ram_address_b=0xF20, ram_wren_a=0.
- Wrap: dma_addr=0xFFFE, len=3 → addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Async reset asserted during beat 2 of a len=7 read burst → all outputs 0 immediately, no dma_rvalid or dma_done afterwards, and IDLE after release.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares the data RAM between the memory stage and a DMA burst loader.
// Define ARB_PERF_COUNTERS_EN to add saturating stall_cycles/dma_beats counters.
module ram_port_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int VADDR_W  = 12,
  parameter int DATA_W   = 8,
  parameter int VEC_W    = 128,
  parameter int MAX_WAIT = 4,
  parameter int LEN_W    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cpu_req,
  input  logic               cpu_we_a,
  input  logic               cpu_we_b,
  input  logic [ADDR_W-1:0]  cpu_addr,
  input  logic [DATA_W-1:0]  cpu_wdata,
  input  logic [VEC_W-1:0]   cpu_vwdata,
  output logic               cpu_stall,
  output logic [DATA_W-1:0]  cpu_rdata,
  output logic [VEC_W-1:0]   cpu_vrdata,
  output logic               cpu_rvalid,
  input  logic               dma_req,
  input  logic               dma_we,
  input  logic [ADDR_W-1:0]  dma_addr,
  input  logic [LEN_W-1:0]   dma_len,
  input  logic [DATA_W-1:0]  dma_wdata,
  output logic               dma_gnt,
  output logic [DATA_W-1:0]  dma_rdata,
  output logic               dma_rvalid,
  output logic               dma_done,
  output logic [ADDR_W-1:0]  ram_address_a,
  output logic [VADDR_W-1:0] ram_address_b,
  output logic [DATA_W-1:0]  ram_data_a,
  output logic [VEC_W-1:0]   ram_data_b,
  output logic               ram_wren_a,
  output logic               ram_wren_b,
  input  logic [DATA_W-1:0]  ram_q_a,
  input  logic [VEC_W-1:0]   ram_q_b
`ifdef ARB_PERF_COUNTERS_EN
  ,
  output logic [31:0]        stall_cycles,
  output logic [31:0]        dma_beats
`endif
);
  localparam logic [1:0] IDLE = 2'd0, CPU_OWN = 2'd1, DMA_BURST = 2'd2;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
  logic [1:0] state;
  logic [LEN_W-1:0] beat, len_q;
  logic [ADDR_W-1:0] base, addr_a_q, dma_cur;
  logic [VADDR_W-1:0] addr_b_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic cpu_tag, dma_tag;
  logic cpu_rq, dma_rq, arb, in_burst, dma_win, cpu_win, dma_act, last;
  // Requests are gated by reset so every output drops to 0 the moment reset asserts.
  assign cpu_rq   = cpu_req & reset;
  assign dma_rq   = dma_req & reset;
  assign in_burst = state == DMA_BURST;
  assign arb      = ~in_burst;
  assign dma_win  = arb & dma_rq & ((wait_cnt == WAIT_MAX) | ~cpu_rq);
  assign cpu_win  = arb & cpu_rq & ~dma_win;
  assign dma_act  = dma_win | in_burst;
  assign last     = in_burst ? beat == len_q : dma_len == '0;
  assign dma_cur  = in_burst ? base + ADDR_W'(beat) : dma_addr;
  assign cpu_stall     = cpu_rq & ~cpu_win;
  assign dma_gnt       = dma_act;
  assign dma_done      = dma_act & last;
  assign ram_address_a = cpu_win ? cpu_addr : dma_act ? dma_cur : addr_a_q;
  assign ram_address_b = cpu_win ? cpu_addr[VADDR_W-1:0] : addr_b_q;
  assign ram_data_a    = cpu_win ? cpu_wdata : dma_act ? dma_wdata : '0;
  assign ram_data_b    = cpu_win ? cpu_vwdata : '0;
  assign ram_wren_a    = (cpu_win & cpu_we_a) | (dma_act & dma_we);
  assign ram_wren_b    = cpu_win & cpu_we_b;
  assign cpu_rvalid    = cpu_tag;
  assign cpu_rdata     = cpu_tag ? ram_q_a : '0;
  assign cpu_vrdata    = cpu_tag ? ram_q_b : '0;
  assign dma_rvalid    = dma_tag;
  assign dma_rdata     = dma_tag ? ram_q_a : '0;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      beat     <= '0;
      len_q    <= '0;
      base     <= '0;
      wait_cnt <= '0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      cpu_tag  <= 1'b0;
      dma_tag  <= 1'b0;
    end else begin
      cpu_tag  <= cpu_win & ~cpu_we_a & ~cpu_we_b;
      dma_tag  <= dma_act & ~dma_we;
      addr_a_q <= ram_address_a;
      addr_b_q <= ram_address_b;
      if (dma_win) begin
        base     <= dma_addr;
        len_q    <= dma_len;
        beat     <= LEN_W'(1);
        wait_cnt <= '0;
        state    <= last ? IDLE : DMA_BURST;
      end else if (in_burst) begin
        beat  <= last ? '0 : beat + 1'b1;
        state <= last ? IDLE : DMA_BURST;
      end else begin
        state    <= cpu_win ? CPU_OWN : IDLE;
        wait_cnt <= !dma_rq ? '0 : (cpu_win && wait_cnt != WAIT_MAX) ? wait_cnt + 1'b1 : wait_cnt;
      end
    end
  end
`ifdef ARB_PERF_COUNTERS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
      dma_beats    <= '0;
    end else begin
      if (cpu_stall && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
      if (dma_gnt && dma_beats != '1) dma_beats <= dma_beats + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: vector table plus burst/starvation/wrap/reset sequences with a read-return scoreboard.
module tb_ram_port_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic cpu_req, cpu_we_a, cpu_we_b, dma_req, dma_we;
  logic [15:0] cpu_addr, dma_addr;
  logic [7:0] cpu_wdata, dma_wdata;
  logic [127:0] cpu_vwdata;
  logic [3:0] dma_len;
  logic cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid, dma_done, ram_wren_a, ram_wren_b;
  logic [7:0] cpu_rdata, dma_rdata, ram_data_a, ram_q_a;
  logic [127:0] cpu_vrdata, ram_data_b, ram_q_b;
  logic [15:0] ram_address_a;
  logic [11:0] ram_address_b;
  int n_pass = 0, n_tot = 0;
  always #5 clk = ~clk;

  ram_port_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we_a(cpu_we_a), .cpu_we_b(cpu_we_b), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_vwdata(cpu_vwdata), .cpu_stall(cpu_stall),
    .cpu_rdata(cpu_rdata), .cpu_vrdata(cpu_vrdata), .cpu_rvalid(cpu_rvalid),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_len(dma_len),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rdata(dma_rdata),
    .dma_rvalid(dma_rvalid), .dma_done(dma_done),
    .ram_address_a(ram_address_a), .ram_address_b(ram_address_b),
    .ram_data_a(ram_data_a), .ram_data_b(ram_data_b),
    .ram_wren_a(ram_wren_a), .ram_wren_b(ram_wren_b),
    .ram_q_a(ram_q_a), .ram_q_b(ram_q_b)
  );

  // Unwritten scalar locations read back a fixed pattern; RAM[0x10] holds 0x5A.
  function automatic logic [7:0] pat(input logic [15:0] a);
    return (a == 16'h0010) ? 8'h5A : a[7:0] ^ 8'hA5;
  endfunction

  logic [7:0] mem_a [65536];
  bit wa [65536];
  logic [127:0] mem_b [4096];
  bit wb [4096];
  always @(posedge clk) begin
    ram_q_a <= wa[ram_address_a] ? mem_a[ram_address_a] : pat(ram_address_a);
    ram_q_b <= wb[ram_address_b] ? mem_b[ram_address_b] : '0;
    if (ram_wren_a) begin
      mem_a[ram_address_a] <= ram_data_a;
      wa[ram_address_a] <= 1'b1;
    end
    if (ram_wren_b) begin
      mem_b[ram_address_b] <= ram_data_b;
      wb[ram_address_b] <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  typedef struct packed {
    logic cv;
    logic dv;
    logic [7:0] d;
    logic [127:0] vd;
  } rd_t;
  rd_t sbq [$];

  task automatic sb_pop();
    rd_t e;
    if (sbq.size() == 0) begin
      n_tot++;
      $display("FAIL scoreboard_empty at %0t", $time);
    end else begin
      e = sbq.pop_front();
      chk("cpu_rvalid", cpu_rvalid, e.cv);
      chk("dma_rvalid", dma_rvalid, e.dv);
      if (e.cv) chk("cpu_rdata", cpu_rdata, e.d);
      if (e.cv) chk("cpu_vrdata", cpu_vrdata, e.vd);
      if (e.dv) chk("dma_rdata", dma_rdata, e.d);
    end
  endtask

  task automatic sb_push(input logic cv, input logic dv, input logic [7:0] d, input logic [127:0] vd);
    rd_t e;
    e.cv = cv;
    e.dv = dv;
    e.d = d;
    e.vd = vd;
    sbq.push_back(e);
  endtask

  task automatic clr();
    cpu_req = 0; cpu_we_a = 0; cpu_we_b = 0; cpu_addr = '0; cpu_wdata = '0; cpu_vwdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_len = '0; dma_wdata = '0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    clr();
    #1;
    sb_pop();
    sb_push(0, 0, 8'h0, '0);
  endtask

  typedef struct {
    logic creq, cwa, cwb;
    logic [15:0] caddr;
    logic [7:0] cwd;
    logic dreq, dwe;
    logic [15:0] daddr;
    logic [7:0] dwd;
    logic stall, gnt, wra, wrb, done;
    logic [15:0] aa;
    logic [11:0] ab;
    logic cv, dv;
    logic [7:0] d;
  } vec_t;
  vec_t tbl [11];

  localparam logic [127:0] VPAT = 128'h000102030405060708090a0b0c0d0e0f;
  logic [15:0] wexp [4];

  initial begin
    tbl[0]  = '{0,0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00, 0,0,0,0,0, 16'h0000,12'h000, 0,0,8'h00};
    tbl[1]  = '{1,0,0,16'h0010,8'h00, 0,0,16'h0000,8'h00, 0,0,0,0,0, 16'h0010,12'h010, 1,0,8'h5A};
    tbl[2]  = '{1,1,0,16'h0020,8'h33, 0,0,16'h0000,8'h00, 0,0,1,0,0, 16'h0020,12'h020, 0,0,8'h00};
    tbl[3]  = '{1,0,0,16'h0020,8'h00, 0,0,16'h0000,8'h00, 0,0,0,0,0, 16'h0020,12'h020, 1,0,8'h33};
    tbl[4]  = '{0,0,0,16'h0000,8'h00, 1,0,16'h0030,8'h00, 0,1,0,0,1, 16'h0030,12'h020, 0,1,8'h95};
    tbl[5]  = '{1,0,0,16'h0040,8'h00, 1,0,16'h0030,8'h00, 0,0,0,0,0, 16'h0040,12'h040, 1,0,8'hE5};
    tbl[6]  = '{0,0,0,16'h0000,8'h00, 1,1,16'h0050,8'h77, 0,1,1,0,1, 16'h0050,12'h040, 0,0,8'h00};
    tbl[7]  = '{0,0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00, 0,0,0,0,0, 16'h0050,12'h040, 0,0,8'h00};
    tbl[8]  = '{0,0,0,16'h0000,8'h00, 1,0,16'h0050,8'h00, 0,1,0,0,1, 16'h0050,12'h040, 0,1,8'h77};
    tbl[9]  = '{1,1,1,16'h0F20,8'h11, 0,0,16'h0000,8'h00, 0,0,1,1,0, 16'h0F20,12'hF20, 0,0,8'h00};
    tbl[10] = '{1,0,0,16'h0F20,8'h00, 0,0,16'h0000,8'h00, 0,0,0,0,0, 16'h0F20,12'hF20, 1,0,8'h11};
    wexp = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};

    // Reset with live requests: everything must read 0.
    clr();
    reset = 0;
    cpu_req = 1; dma_req = 1; dma_we = 1; dma_addr = 16'h1234; cpu_addr = 16'h4321; cpu_we_a = 1;
    #2;
    chk("rst_stall", cpu_stall, 0);
    chk("rst_gnt", dma_gnt, 0);
    chk("rst_done", dma_done, 0);
    chk("rst_wren", {ram_wren_a, ram_wren_b}, 0);
    chk("rst_addr", {ram_address_a, ram_address_b}, 0);
    chk("rst_rvalid", {cpu_rvalid, dma_rvalid}, 0);
    @(negedge clk);
    clr();
    @(negedge clk);
    reset = 1;
    sb_push(0, 0, 8'h0, '0);

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      cpu_req = tbl[i].creq; cpu_we_a = tbl[i].cwa; cpu_we_b = tbl[i].cwb;
      cpu_addr = tbl[i].caddr; cpu_wdata = tbl[i].cwd; cpu_vwdata = '0;
      dma_req = tbl[i].dreq; dma_we = tbl[i].dwe; dma_addr = tbl[i].daddr;
      dma_len = '0; dma_wdata = tbl[i].dwd;
      #1;
      chk($sformatf("v%0d_stall", i), cpu_stall, tbl[i].stall);
      chk($sformatf("v%0d_gnt", i), dma_gnt, tbl[i].gnt);
      chk($sformatf("v%0d_done", i), dma_done, tbl[i].done);
      chk($sformatf("v%0d_wren_a", i), ram_wren_a, tbl[i].wra);
      chk($sformatf("v%0d_wren_b", i), ram_wren_b, tbl[i].wrb);
      chk($sformatf("v%0d_addr_a", i), ram_address_a, tbl[i].aa);
      chk($sformatf("v%0d_addr_b", i), ram_address_b, tbl[i].ab);
      sb_pop();
      sb_push(tbl[i].cv, tbl[i].dv, tbl[i].d, '0);
    end
    idle_cycle();

    // DMA write burst from idle; CPU asks from beat 1, dma_req drops mid-burst.
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      cpu_req = (b > 0); cpu_addr = 16'h0010;
      dma_req = (b < 2); dma_we = 1;
      dma_addr = (b == 0) ? 16'h0100 : 16'hDEAD;
      dma_len = (b == 0) ? 4'd3 : 4'd0;
      dma_wdata = 8'hC0 + 8'(b);
      #1;
      chk($sformatf("burst%0d_gnt", b), dma_gnt, 1);
      chk($sformatf("burst%0d_addr", b), ram_address_a, 16'h0100 + 16'(b));
      chk($sformatf("burst%0d_wren", b), {ram_wren_a, ram_wren_b}, 2'b10);
      chk($sformatf("burst%0d_done", b), dma_done, b == 3);
      chk($sformatf("burst%0d_stall", b), cpu_stall, b > 0);
      sb_pop();
      sb_push(0, 0, 8'h0, '0);
    end
    @(negedge clk);
    dma_req = 0; cpu_req = 1; cpu_addr = 16'h0010;
    #1;
    chk("post_burst_stall", cpu_stall, 0);
    chk("post_burst_gnt", dma_gnt, 0);
    sb_pop();
    sb_push(1, 0, 8'h5A, '0);
    idle_cycle();
    for (int b = 0; b < 4; b++) chk($sformatf("burst_mem%0d", b), mem_a[16'h0100 + b], 8'hC0 + 8'(b));

    // Starvation: CPU wins 4 cycles, then a 2-beat DMA burst, then CPU again.
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      cpu_req = 1; cpu_addr = 16'h0010;
      dma_req = 1; dma_we = 1; dma_addr = 16'h0200; dma_len = 4'd1; dma_wdata = 8'hD0 + 8'(c);
      #1;
      chk($sformatf("starve%0d_stall", c), cpu_stall, c == 4 || c == 5);
      chk($sformatf("starve%0d_gnt", c), dma_gnt, c == 4 || c == 5);
      chk($sformatf("starve%0d_done", c), dma_done, c == 5);
      chk($sformatf("starve%0d_addr", c), ram_address_a,
          (c == 4) ? 16'h0200 : (c == 5) ? 16'h0201 : 16'h0010);
      sb_pop();
      sb_push(c < 4 || c == 6, 0, 8'h5A, '0);
    end
    idle_cycle();

    // Vector store, then read it back through port b.
    @(negedge clk);
    clr();
    cpu_req = 1; cpu_we_b = 1; cpu_addr = 16'h0F20; cpu_vwdata = VPAT;
    #1;
    chk("vst_wren_b", ram_wren_b, 1);
    chk("vst_wren_a", ram_wren_a, 0);
    chk("vst_addr_b", ram_address_b, 12'hF20);
    chk("vst_data_b", ram_data_b, VPAT);
    chk("vst_stall", cpu_stall, 0);
    sb_pop();
    sb_push(0, 0, 8'h0, '0);
    @(negedge clk);
    clr();
    cpu_req = 1; cpu_addr = 16'h0F20;
    #1;
    sb_pop();
    sb_push(1, 0, 8'h11, VPAT);
    idle_cycle();

    // Address wrap across 0xFFFF.
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      clr();
      dma_req = (b == 0); dma_we = 1; dma_addr = 16'hFFFE; dma_len = 4'd3; dma_wdata = 8'hE0 + 8'(b);
      #1;
      chk($sformatf("wrap%0d_addr", b), ram_address_a, wexp[b]);
      chk($sformatf("wrap%0d_done", b), dma_done, b == 3);
      sb_pop();
      sb_push(0, 0, 8'h0, '0);
    end
    idle_cycle();
    chk("wrap_mem", mem_a[16'h0001], 8'hE3);

    // Reset during beat 2 of a len=7 read burst.
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      clr();
      dma_req = 1; dma_we = 0; dma_addr = 16'h0300; dma_len = 4'd7; cpu_req = (b == 2);
      #1;
      chk($sformatf("rdb%0d_addr", b), ram_address_a, 16'h0300 + 16'(b));
      sb_pop();
      if (b < 2) sb_push(0, 1, pat(16'h0300 + 16'(b)), '0);
    end
    chk("rdb2_stall", cpu_stall, 1);
    #1;
    reset = 0;
    #1;
    chk("mid_rst_gnt", dma_gnt, 0);
    chk("mid_rst_done", dma_done, 0);
    chk("mid_rst_stall", cpu_stall, 0);
    chk("mid_rst_rvalid", {cpu_rvalid, dma_rvalid}, 0);
    chk("mid_rst_addr", ram_address_a, 0);
    chk("mid_rst_wdata", {ram_data_a, ram_wren_a}, 0);
    sbq.delete();
    sb_push(0, 0, 8'h0, '0);
    @(negedge clk);
    clr();
    reset = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("after_rst%0d_gnt", c), dma_gnt, 0);
      chk($sformatf("after_rst%0d_done", c), dma_done, 0);
      sb_pop();
      sb_push(0, 0, 8'h0, '0);
      @(negedge clk);
    end
    cpu_req = 1; cpu_addr = 16'h0010;
    #1;
    chk("after_rst_idle_stall", cpu_stall, 0);
    chk("after_rst_idle_addr", ram_address_a, 16'h0010);
    sb_pop();
    sb_push(1, 0, 8'h5A, '0);
    idle_cycle();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
